// File: rtl/risc8_pkg.sv
// Shared constants and read-owner encoding for the risc8 RAM port.
// Used by the arbiter and the parent that instantiates the RAM.
package risc8_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } own_e;

endpackage

// File: rtl/risc8_ram_arb.sv
// CPU/DMA arbiter for one single-port RAM with a starvation wait counter.
// Define RISC8_RAM_ARB_RR_EN for round-robin contention, else cpu wins.
module risc8_ram_arb
  import risc8_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_wen,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [WW-1:0] cpu_wait;
  logic [WW-1:0] dma_wait;
  own_e          rd_own;
  logic          dma_wins;
  logic          base_dma;

`ifdef RISC8_RAM_ARB_RR_EN
  logic prio_dma;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_dma <= 1'b0;
    end else if (cpu_gnt) begin
      prio_dma <= 1'b1;
    end else if (dma_gnt) begin
      prio_dma <= 1'b0;
    end
  end

  assign base_dma = prio_dma;
`else
  assign base_dma = 1'b0;
`endif

  // A saturated wait counter overrides the base policy
  always_comb begin
    if (dma_wait == WMAX) begin
      dma_wins = 1'b1;
    end else if (cpu_wait == WMAX) begin
      dma_wins = 1'b0;
    end else begin
      dma_wins = base_dma;
    end
  end

  assign cpu_gnt = !reset && cpu_req
                   && (!dma_req || !dma_wins);
  assign dma_gnt = !reset && dma_req
                   && (!cpu_req || dma_wins);

  always_comb begin
    ram_wen   = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (dma_gnt) begin
      ram_wen   = dma_wen;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else if (cpu_gnt) begin
      ram_wen = cpu_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_wait <= '0;
      dma_wait <= '0;
    end else begin
      if (!cpu_req || cpu_gnt) begin
        cpu_wait <= '0;
      end else if (cpu_wait != WMAX) begin
        cpu_wait <= cpu_wait + WW'(1);
      end
      if (!dma_req || dma_gnt) begin
        dma_wait <= '0;
      end else if (dma_wait != WMAX) begin
        dma_wait <= dma_wait + WW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_own <= OWN_NONE;
    end else if (cpu_gnt && !cpu_wen) begin
      rd_own <= OWN_CPU;
    end else if (dma_gnt && !dma_wen) begin
      rd_own <= OWN_DMA;
    end else begin
      rd_own <= OWN_NONE;
    end
  end

  // Reset arriving right after a read grant drops the pending pulse
  assign cpu_rvalid = (rd_own == OWN_CPU) && !reset;
  assign dma_rvalid = (rd_own == OWN_DMA) && !reset;
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;

endmodule

// File: tb/tb_risc8_ram_arb.sv
// Bench for risc8_ram_arb: vector table plus multi-cycle sequences.
// Honours RISC8_RAM_ARB_RR_EN for the contention expectations.
module tb_risc8_ram_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wen, dma_req, dma_wen;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        ram_wen;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  risc8_ram_arb dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_wen(dma_wen),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
    .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
    .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:65535];
  logic [7:0] exp_mem [0:65535];

  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        rst;
    logic        cr, cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        dr, dw;
    logic [15:0] da;
    logic [7:0]  dd;
    logic        ec, ed;
  } vec_t;

  typedef struct {
    logic       cv, dv;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, req);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic cr, input logic cw,
    input logic [15:0] ca, input logic [7:0] cd,
    input logic dr, input logic dw,
    input logic [15:0] da, input logic [7:0] dd,
    input logic ec, input logic ed);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ec = ec; v.ed = ed;
    return v;
  endfunction

  // One clock: pop last cycle's read expectation, check grant, push next
  task automatic cyc(input vec_t v);
    exp_t e, n;
    reset = v.rst;
    cpu_req = v.cr; cpu_wen = v.cw;
    cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_req = v.dr; dma_wen = v.dw;
    dma_addr = v.da; dma_wdata = v.dd;
    @(negedge clk);
    e = sbq.pop_front();
    if (v.rst) begin
      e.cv = 1'b0;
      e.dv = 1'b0;
    end
    chk("cpu_rvalid", int'(cpu_rvalid), int'(e.cv));
    chk("dma_rvalid", int'(dma_rvalid), int'(e.dv));
    if (e.cv) chk("cpu_rdata", int'(cpu_rdata), int'(e.data));
    if (e.dv) chk("dma_rdata", int'(dma_rdata), int'(e.data));
    chk("cpu_gnt", int'(cpu_gnt), int'(v.ec));
    chk("dma_gnt", int'(dma_gnt), int'(v.ed));
    n.cv = 1'b0; n.dv = 1'b0; n.data = 8'h00;
    if (v.ed) begin
      chk("ram_wen", int'(ram_wen), int'(v.dw));
      chk("ram_addr", int'(ram_addr), int'(v.da));
      if (v.dw) begin
        chk("ram_wdata", int'(ram_wdata), int'(v.dd));
        exp_mem[v.da] = v.dd;
      end else begin
        n.dv = 1'b1;
        n.data = exp_mem[v.da];
      end
    end else if (v.ec) begin
      chk("ram_wen", int'(ram_wen), int'(v.cw));
      chk("ram_addr", int'(ram_addr), int'(v.ca));
      if (v.cw) begin
        chk("ram_wdata", int'(ram_wdata), int'(v.cd));
        exp_mem[v.ca] = v.cd;
      end else begin
        n.cv = 1'b1;
        n.data = exp_mem[v.ca];
      end
    end else begin
      chk("ram_wen_idle", int'(ram_wen), 0);
      chk("ram_addr_idle", int'(ram_addr), int'(v.ca));
      chk("ram_wdata_idle", int'(ram_wdata), int'(v.cd));
    end
    sbq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idle(input logic rst);
    return mk(rst, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  vec_t tbl[8];

  initial begin
    exp_t z;
    logic ec;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i[7:0] ^ i[15:8] ^ 8'h3C);
      exp_mem[i] = 8'(i[7:0] ^ i[15:8] ^ 8'h3C);
    end
    mem[16'h1234]     = 8'h5A;
    exp_mem[16'h1234] = 8'h5A;

    tbl[0] = idle(1'b0);
    tbl[1] = mk(0, 1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 0);
    tbl[2] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h00FF, 8'h00, 0, 1);
    tbl[3] = mk(0, 1, 1, 16'h0200, 8'h77, 0, 0, 16'h0000, 8'h00, 1, 0);
    tbl[4] = mk(0, 0, 0, 16'h0042, 8'h99, 1, 1, 16'h0300, 8'h11, 0, 1);
    tbl[5] = mk(0, 1, 0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 0);
    tbl[6] = mk(0, 0, 0, 16'h0055, 8'h66, 1, 0, 16'h0300, 8'h00, 0, 1);
    tbl[7] = mk(0, 0, 0, 16'h0ABC, 8'hDE, 0, 0, 16'h0000, 8'h00, 0, 0);

    z.cv = 1'b0; z.dv = 1'b0; z.data = 8'h00;
    sbq.push_back(z);
    reset = 1'b1;
    cpu_req = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wen = 0; dma_addr = 0; dma_wdata = 0;
    @(posedge clk);
    #1;

    // reset holds off a pending request, then it wins at once
    for (int i = 0; i < 3; i++)
      cyc(mk(1, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h0, 0, 0));
    cyc(mk(0, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h0, 1, 0));
    cyc(idle(1'b0));

    for (int i = 0; i < 8; i++) cyc(tbl[i]);

    // dma write then cpu read of the same byte
    cyc(mk(0, 0, 0, 16'h0, 8'h0, 1, 1, 16'h8001, 8'hA5, 0, 1));
    cyc(mk(0, 1, 0, 16'h8001, 8'h0, 0, 0, 16'h0, 8'h0, 1, 0));
    cyc(idle(1'b0));
    chk("mem_8001", int'(mem[16'h8001]), 32'hA5);

    // continuous contention from a clean reset
    cyc(idle(1'b1));
    for (int k = 1; k <= 34; k++) begin
`ifdef RISC8_RAM_ARB_RR_EN
      ec = (k % 2) == 1;
`else
      ec = (k % 16) != 0;
`endif
      cyc(mk(0, 1, 0, 16'(k), 8'h0,
             1, 0, 16'(16'h4000 + k), 8'h0, ec, !ec));
    end
    cyc(idle(1'b0));

    // reset right after a dma read grant kills its rvalid
    cyc(mk(0, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0777, 8'h0, 0, 1));
    cyc(mk(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0777, 8'h0, 0, 0));
    cyc(idle(1'b0));
    cyc(idle(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
